// File: rtl/aes_chain_ctrl.sv
// ECB/CBC chaining controller around an iterative AES core.
// Input and output block FIFOs, one block in flight at the core, chain register for CBC.
module aes_chain_ctrl #(
   parameter int BLK_W = 128,
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic             mclk,
   input  logic             rst,
   input  logic             cfg_mode,
   input  logic             cfg_decr,
   input  logic [BLK_W-1:0] cfg_iv,
   input  logic             cfg_iv_ld,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [BLK_W-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [BLK_W-1:0] out_data,
   output logic             core_ld,
   output logic [BLK_W-1:0] core_text_in,
   input  logic             core_done,
   input  logic [BLK_W-1:0] core_text_out,
   output logic             busy,
   output logic [CNT_W-1:0] blk_cnt,
   output logic             iv_err
);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, LOAD, WAIT, STORE} state_t;
   state_t state_reg, state_next;

   logic [BLK_W-1:0] in_mem  [DEPTH];
   logic [BLK_W-1:0] out_mem [DEPTH];
   logic [AW:0]      in_wr_reg, in_rd_reg, out_wr_reg, out_rd_reg;
   logic             run_reg, mode_reg, decr_reg, iv_err_reg;
   logic [BLK_W-1:0] chain_reg, hold_reg, res_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic             in_empty, in_full, out_empty, out_full;
   logic             in_push, in_pop, out_push, out_pop, iv_ok;
   logic [BLK_W-1:0] in_head, store_data;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign in_empty  = (in_wr_reg == in_rd_reg);
   assign in_full   = (in_wr_reg == {~in_rd_reg[AW], in_rd_reg[AW-1:0]});
   assign out_empty = (out_wr_reg == out_rd_reg);
   assign out_full  = (out_wr_reg == {~out_rd_reg[AW], out_rd_reg[AW-1:0]});

   assign in_ready  = run_reg & ~in_full;
   assign in_push   = in_valid & in_ready;
   assign out_valid = ~out_empty;
   assign out_pop   = out_valid & out_ready;
   assign in_head   = in_mem[in_rd_reg[AW-1:0]];
   assign out_data  = out_mem[out_rd_reg[AW-1:0]];

   assign core_text_in = (cfg_mode & ~cfg_decr) ? (in_head ^ chain_reg) : in_head;
   assign store_data   = (mode_reg & decr_reg) ? (res_reg ^ chain_reg) : res_reg;
   assign iv_ok        = (state_reg == IDLE) & in_empty;

   assign busy    = (state_reg != IDLE) | ~in_empty;
   assign blk_cnt = cnt_reg;
   assign iv_err  = iv_err_reg;

   always_comb begin
      state_next = state_reg;
      core_ld    = 1'b0;
      in_pop     = 1'b0;
      out_push   = 1'b0;
      case (state_reg)
         // Reserve the output slot before starting, so STORE can never overflow.
         IDLE:    if (!in_empty && (!out_full || out_pop)) state_next = LOAD;
         LOAD: begin
            core_ld    = 1'b1;
            in_pop     = 1'b1;
            state_next = WAIT;
         end
         WAIT:    if (core_done) state_next = STORE;
         STORE: begin
            out_push   = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge mclk) begin
      if (in_push)  in_mem[in_wr_reg[AW-1:0]]   <= in_data;
      if (out_push) out_mem[out_wr_reg[AW-1:0]] <= store_data;
   end

   always_ff @(posedge mclk or posedge rst) begin
      if (rst) begin
         state_reg  <= IDLE;
         run_reg    <= 1'b0;
         in_wr_reg  <= '0;
         in_rd_reg  <= '0;
         out_wr_reg <= '0;
         out_rd_reg <= '0;
         mode_reg   <= 1'b0;
         decr_reg   <= 1'b0;
         chain_reg  <= '0;
         hold_reg   <= '0;
         res_reg    <= '0;
         cnt_reg    <= '0;
         iv_err_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         run_reg   <= 1'b1;
         if (in_push)  in_wr_reg  <= in_wr_reg + 1'b1;
         if (in_pop)   in_rd_reg  <= in_rd_reg + 1'b1;
         if (out_push) out_wr_reg <= out_wr_reg + 1'b1;
         if (out_pop)  out_rd_reg <= out_rd_reg + 1'b1;
         if (state_reg == LOAD) begin
            mode_reg <= cfg_mode;
            decr_reg <= cfg_decr;
            hold_reg <= in_head;
         end
         if (state_reg == WAIT && core_done) res_reg <= core_text_out;
         if (state_reg == STORE) begin
            cnt_reg <= cnt_reg + 1'b1;
            if (mode_reg) chain_reg <= decr_reg ? hold_reg : res_reg;
         end
         if (cfg_iv_ld) begin
            if (iv_ok) chain_reg  <= cfg_iv;
            else       iv_err_reg <= 1'b1;
         end
      end
   end
endmodule
